// File: rtl/ysyx_25020047_pkg.sv
// ysyx_25020047_pkg: LSU op codes and FSM state encoding
package ysyx_25020047_pkg;
    localparam logic [3:0] LSU_LB  = 4'h0;
    localparam logic [3:0] LSU_LH  = 4'h1;
    localparam logic [3:0] LSU_LW  = 4'h2;
    localparam logic [3:0] LSU_LBU = 4'h4;
    localparam logic [3:0] LSU_LHU = 4'h5;
    localparam logic [3:0] LSU_SB  = 4'h8;
    localparam logic [3:0] LSU_SH  = 4'h9;
    localparam logic [3:0] LSU_SW  = 4'hA;
    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_RESP, LSU_DONE} lsu_state_e;
endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// ysyx_25020047_lsu_align: byte-lane strobes, store replication, load extraction and alignment check
module ysyx_25020047_lsu_align
    import ysyx_25020047_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] lane_wdata,
    output logic [31:0] ldata,
    output logic        misalign
);
    logic        legal;
    logic [31:0] sh;
    always_comb begin
        legal      = op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW};
        // illegal codes are folded into the fault path so they never reach the bus
        misalign   = !legal || (op[1:0] == 2'd1 && addr_lo[0]) || (op[1:0] == 2'd2 && addr_lo != 2'd0);
        sh         = rdata >> {addr_lo, 3'b000};
        wstrb      = !op[3] ? 4'b0000 :
                     op[1:0] == 2'd0 ? 4'b0001 << addr_lo :
                     op[1:0] == 2'd1 ? 4'b0011 << {addr_lo[1], 1'b0} : 4'b1111;
        lane_wdata = op[1:0] == 2'd0 ? {4{wdata[7:0]}} :
                     op[1:0] == 2'd1 ? {2{wdata[15:0]}} : wdata;
        ldata      = op[1:0] == 2'd0 ? {{24{sh[7] & !op[2]}}, sh[7:0]} :
                     op[1:0] == 2'd1 ? {{16{sh[15] & !op[2]}}, sh[15:0]} : sh;
    end
endmodule

// File: rtl/ysyx_25020047_lsu.sv
// ysyx_25020047_lsu: multi-cycle load/store unit on a req/gnt/rvalid bus
module ysyx_25020047_lsu
    import ysyx_25020047_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [4:0]        in_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic [4:0]        out_rd,
    output logic              out_wen,
    output logic              out_misalign
);
    lsu_state_e        state;
    logic [3:0]        op_q;
    logic [1:0]        lo_q;
    logic [3:0]        wstrb;
    logic [DATA_W-1:0] lane, ldata;
    logic              mis;

    assign in_ready  = state == LSU_IDLE;
    assign mem_req   = state == LSU_REQ;
    assign out_valid = state == LSU_DONE;

    // the aligner sees the incoming op while idle and the latched op afterwards
    ysyx_25020047_lsu_align u_align (
        .op         (in_ready ? in_op : op_q),
        .addr_lo    (in_ready ? in_addr[1:0] : lo_q),
        .wdata      (in_wdata),
        .rdata      (mem_rdata),
        .wstrb      (wstrb),
        .lane_wdata (lane),
        .ldata      (ldata),
        .misalign   (mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LSU_IDLE;
            op_q         <= '0;
            lo_q         <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            out_rdata    <= '0;
            out_rd       <= '0;
            out_wen      <= 1'b0;
            out_misalign <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: if (in_valid) begin
                    op_q         <= in_op;
                    lo_q         <= in_addr[1:0];
                    out_rd       <= in_rd;
                    out_misalign <= mis;
                    out_wen      <= 1'b0;
                    out_rdata    <= '0;
                    mem_we       <= in_op[3] && !mis;
                    mem_addr     <= {in_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata    <= lane;
                    mem_wstrb    <= mis ? 4'b0000 : wstrb;
                    state        <= mis ? LSU_DONE : LSU_REQ;
                end
                LSU_REQ:  if (mem_gnt) state <= LSU_RESP;
                LSU_RESP: if (mem_rvalid) begin
                    out_rdata <= op_q[3] ? '0 : ldata;
                    out_wen   <= !op_q[3] && out_rd != 5'd0;
                    state     <= LSU_DONE;
                end
                LSU_DONE: if (out_ready) state <= LSU_IDLE;
                default:  state <= LSU_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// tb_ysyx_25020047_lsu: directed vectors with request/result scoreboards for the LSU
module tb_ysyx_25020047_lsu;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [3:0]  in_op = '0;
    logic [31:0] in_addr = '0, in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_wstrb;
    logic        out_valid, out_ready = 1'b1, out_wen, out_misalign;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;

    always #5 clk = ~clk;

    ysyx_25020047_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
        .out_wen(out_wen), .out_misalign(out_misalign)
    );

    typedef struct { logic [31:0] rdata; logic [4:0] rd; logic wen; logic mis; int lat; } out_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; } req_t;
    out_t out_q[$];
    req_t req_q[$];
    int n_cmp = 0, n_fail = 0, cyc = 0, acc_cyc = 0, n_gnt = 0;
    int gnt_delay = 0, rv_delay = 0;
    logic [31:0] rd_val = '0;
    bit auto_bus = 1'b1, stray = 1'b0, prev_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // bus responder: optional gnt stall, then rvalid; stray rvalid in REQ and DONE when enabled
    initial forever begin
        @(negedge clk);
        if (auto_bus && mem_req) begin
            for (int i = 0; i < gnt_delay; i++) begin
                mem_rvalid = stray;
                mem_rdata  = 32'hBADBAD00;
                @(negedge clk);
            end
            mem_rvalid = 1'b0;
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            repeat (rv_delay) @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = rd_val;
            @(negedge clk);
            mem_rvalid = stray;
            mem_rdata  = ~rd_val;
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk); #1;
        if (mem_req) begin
            if (req_q.size() == 0) check("spurious_req", 32'(mem_req), 32'd0);
            else begin
                check("req_we", 32'(mem_we), 32'(req_q[0].we));
                check("req_addr", mem_addr, req_q[0].addr);
                check("req_wdata", mem_wdata, req_q[0].wdata);
                check("req_wstrb", 32'(mem_wstrb), 32'(req_q[0].strb));
                if (mem_gnt) begin
                    void'(req_q.pop_front());
                    n_gnt++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk); #1;
        if (out_valid) begin
            check("busy_in_ready", 32'(in_ready), 32'd0);
            if (out_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
            else begin
                if (!prev_v && out_q[0].lat != 0) check("latency", 32'(cyc - acc_cyc + 1), 32'(out_q[0].lat));
                check("out_rdata", out_rdata, out_q[0].rdata);
                check("out_rd", 32'(out_rd), 32'(out_q[0].rd));
                check("out_wen", 32'(out_wen), 32'(out_q[0].wen));
                check("out_misalign", 32'(out_misalign), 32'(out_q[0].mis));
                if (out_ready) void'(out_q.pop_front());
            end
        end
        prev_v = out_valid && !out_ready;
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) check("in_ready_timeout", 32'(ok), 32'd1);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd; in_rd = rd;
        @(posedge clk); #1;
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0; in_op = 4'hA; in_addr = '1; in_wdata = '1; in_rd = '1;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = out_q.size() == 0 && req_q.size() == 0;
        end
        if (!ok) check("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] mdata, input logic [4:0] rd, input bit hasreq,
                       input logic we, input logic [31:0] maddr, input logic [31:0] mwd,
                       input logic [3:0] strb, input logic [31:0] ordata, input logic wen,
                       input logic mis, input int lat);
        rd_val = mdata;
        if (hasreq) req_q.push_back('{we, maddr, mwd, strb});
        out_q.push_back('{ordata, rd, wen, mis, lat});
        issue(op, addr, wd, rd);
        wait_done();
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_wen", 32'(out_wen), 32'd0);
        check("rst_out_misalign", 32'(out_misalign), 32'd0);
        check("rst_out_rdata", out_rdata, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g0;
        #12;
        check_reset_outputs();
        @(negedge clk) rst_n = 1'b1;
        //  op     addr          wdata         mem rdata     rd  rq we mem_addr      mem_wdata     strb   out_rdata     wen mis lat
        run(4'h2, 32'h80000004, 32'h0,        32'hDEADBEEF, 5,  1, 0, 32'h80000004, 32'h0,        4'h0, 32'hDEADBEEF, 1, 0, 3);
        run(4'h0, 32'h80000003, 32'h0,        32'h80FF1234, 6,  1, 0, 32'h80000000, 32'h0,        4'h0, 32'hFFFFFF80, 1, 0, 3);
        run(4'h4, 32'h80000003, 32'h0,        32'h80FF1234, 6,  1, 0, 32'h80000000, 32'h0,        4'h0, 32'h00000080, 1, 0, 3);
        run(4'h5, 32'h80000002, 32'h0,        32'h80FF1234, 11, 1, 0, 32'h80000000, 32'h0,        4'h0, 32'h000080FF, 1, 0, 3);
        run(4'h1, 32'h80000002, 32'h0,        32'h80FF1234, 12, 1, 0, 32'h80000000, 32'h0,        4'h0, 32'hFFFF80FF, 1, 0, 3);
        run(4'h0, 32'h80000000, 32'h0,        32'h0000007F, 13, 1, 0, 32'h80000000, 32'h0,        4'h0, 32'h0000007F, 1, 0, 3);
        run(4'h2, 32'h80000010, 32'h0,        32'h11223344, 0,  1, 0, 32'h80000010, 32'h0,        4'h0, 32'h11223344, 0, 0, 3);
        run(4'h9, 32'h80000002, 32'h0000ABCD, 32'h0,        7,  1, 1, 32'h80000000, 32'hABCDABCD, 4'hC, 32'h0,        0, 0, 3);
        run(4'h8, 32'h80000001, 32'h12345678, 32'h0,        8,  1, 1, 32'h80000000, 32'h78787878, 4'h2, 32'h0,        0, 0, 3);
        run(4'h8, 32'h80000003, 32'h000000AB, 32'h0,        8,  1, 1, 32'h80000000, 32'hABABABAB, 4'h8, 32'h0,        0, 0, 3);
        run(4'hA, 32'h80000008, 32'hCAFEF00D, 32'h0,        10, 1, 1, 32'h80000008, 32'hCAFEF00D, 4'hF, 32'h0,        0, 0, 3);
        run(4'h2, 32'h80000001, 32'h0,        32'h0,        3,  0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0, 1, 1);
        run(4'h1, 32'h80000003, 32'h0,        32'h0,        4,  0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0, 1, 1);
        run(4'h9, 32'h80000001, 32'h00001234, 32'h0,        4,  0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0, 1, 1);
        run(4'h3, 32'h80000000, 32'h0,        32'h0,        9,  0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0, 1, 1);
        run(4'hB, 32'h80000000, 32'h0,        32'h0,        9,  0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        0, 1, 1);

        // backpressure: gnt stalled 3 cycles with stray rvalid, out_ready low for 2 cycles
        gnt_delay = 3; rv_delay = 1; stray = 1'b1; rd_val = 32'h5A5AA5A5; out_ready = 1'b0;
        g0 = n_gnt;
        req_q.push_back('{1'b0, 32'h80000020, 32'h0, 4'h0});
        out_q.push_back('{32'h5A5AA5A5, 5'd14, 1'b1, 1'b0, 0});
        issue(4'h2, 32'h80000020, 32'h0, 5'd14);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clk);
                ok = out_valid;
            end
            if (!ok) check("bp_valid_timeout", 32'(ok), 32'd1);
        end
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        wait_done();
        check("bp_one_txn", 32'(n_gnt - g0), 32'd1);
        gnt_delay = 0; rv_delay = 0; stray = 1'b0;
        repeat (3) @(negedge clk);

        // reset during RESP, then a stray rvalid after release
        auto_bus = 1'b0;
        req_q.push_back('{1'b0, 32'h80000040, 32'h0, 4'h0});
        issue(4'h2, 32'h80000040, 32'h0, 5'd9);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("stray_out_valid", 32'(out_valid), 32'd0);
        check("stray_in_ready", 32'(in_ready), 32'd1);
        check("stray_out_rdata", out_rdata, 32'd0);
        auto_bus = 1'b1;
        run(4'h2, 32'h80000044, 32'h0, 32'h0BADF00D, 15, 1, 0, 32'h80000044, 32'h0, 4'h0, 32'h0BADF00D, 1, 0, 3);

        check("req_q_empty", 32'(req_q.size()), 32'd0);
        check("out_q_empty", 32'(out_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_25020047_lsu.md
# ysyx_25020047_lsu

Multi-cycle load/store unit sitting directly downstream of the execute stage: it accepts the effective address computed by EXU (`rdata1 + imm`), the store data (`rdata2`) and the memory op, runs one transaction on a simple req/gnt/rvalid memory bus, and hands the aligned, extended load result (or a store-retire token) to write-back. It replaces the EXU's bare `read` flag with a real handshaked memory access and supports all RV32I byte, half and word loads and stores.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; only 32 is supported

- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  EXU presents an op
- `in_ready`  out  1  LSU can accept; high only in IDLE
- `in_op`  in  4  bit 3: 1 = store; bits [2:0]: RV32I funct3
- `in_addr`  in  ADDR_W  effective byte address
- `in_wdata`  in  DATA_W  store data, low-aligned
- `in_rd`  in  5  destination register
- `mem_req`  out  1  bus request, held until `mem_gnt`
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_W  word address, `{in_addr[31:2],2'b00}`
- `mem_wdata`  out  DATA_W  lane-replicated store data
- `mem_wstrb`  out  4  byte enables; 0 for loads
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  response; read data for loads, write ack for stores
- `mem_rdata`  in  DATA_W  read word
- `out_valid`  out  1  result for WBU
- `out_ready`  in  1  WBU accepts
- `out_rdata`  out  DATA_W  extended load data; 0 for stores/faults
- `out_rd`  out  5  latched `in_rd`
- `out_wen`  out  1  1 for a successful load with `rd != 0`
- `out_misalign`  out  1  access was misaligned, not issued

## Operation
- Legal ops: LB 0x0, LH 0x1, LW 0x2, LBU 0x4, LHU 0x5, SB 0x8, SH 0x9, SW 0xA. Any other code is treated as a misaligned fault (`out_misalign=1`).
- Accept when `in_valid && in_ready`. Latch op, addr, wdata and rd.
- Misaligned check:
  - halfword: `addr[0] != 0`
  - word: `addr[1:0] != 0`
  - A misaligned op skips the bus, goes straight to DONE with `out_misalign=1`, `out_wen=0`, `out_rdata=0`.
- Store strobes: SB `4'b0001 << addr[1:0]`; SH `4'b0011 << {addr[1],1'b0}`; SW `4'b1111`.
- Store data: SB `{4{wdata[7:0]}}`; SH `{2{wdata[15:0]}}`; SW `wdata`.
- Load extraction:
  - Shift `mem_rdata` right by `addr[1:0]*8`, take the low 8 or 16 bits.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - `out_rdata` is registered on the `mem_rvalid` cycle.
- FSM:
  - IDLE: wait for accept. Aligned → REQ; misaligned → DONE.
  - REQ: `mem_req=1`, request fields stable. On `mem_gnt` → RESP.
  - RESP: wait for `mem_rvalid` → DONE.
  - DONE: `out_valid=1`, outputs stable. On `out_ready` → IDLE.
- Stores also retire through DONE, with `out_wen=0`, so WBU/PC advance uniformly.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, so `in_ready=1`
  - `mem_req`, `mem_we`, `mem_wstrb`, `out_valid`, `out_wen`, `out_misalign` = 0
  - `mem_addr`, `mem_wdata`, `out_rdata`, `out_rd` = 0
- `mem_*` and `out_*` are driven from registers or decoded from state only; there are no combinational paths from `in_*` to outputs.
- Best-case latency, with `gnt` and `rvalid` each arriving on first opportunity:
  - accept at cycle 0
  - `mem_req` at cycle 1 (gnt same cycle)
  - RESP at cycle 2 (rvalid)
  - `out_valid` at cycle 3
- Misaligned op: `out_valid` at cycle 1.
- `mem_rvalid` is sampled only in RESP. `rvalid` in IDLE, REQ or DONE is ignored; the bus guarantees a response no earlier than the cycle after gnt.
- `mem_req` stays high with unchanged fields across any number of gnt-stall cycles.
- `out_valid` stays high with unchanged data across any number of `out_ready`-low cycles.
- Throughput: one op per 4 cycles minimum. `in_ready` rises the cycle after the DONE handshake.
- Reset mid-transaction (REQ/RESP/DONE): the op is abandoned and `mem_req` drops at once. A late `rvalid` arriving after reset is ignored.

## Structure
- Package `ysyx_25020047_pkg`:
  - op code localparams (`LSU_LB` … `LSU_SW`)
  - FSM state encoding (`LSU_IDLE`, `LSU_REQ`, `LSU_RESP`, `LSU_DONE`)
- One combinational sub-module `ysyx_25020047_lsu_align`:
  - inputs: op, `addr[1:0]`, wdata, rdata
  - outputs: wstrb, lane wdata, extended load data, misalign flag
- The top level holds the FSM and registers only.

## Test plan
- LW at addr 0x80000004, gnt immediate, rdata 0xDEADBEEF at first RESP cycle → `mem_addr=0x80000004`, `mem_wstrb=0`, `out_valid` at cycle 3, `out_rdata=0xDEADBEEF`, `out_wen=1`.
- LB at addr 0x80000003, rdata 0x80FF1234 → `out_rdata=0xFFFFFF80`. LBU at the same address → `0x00000080`. LHU at 0x80000002 → `0x000080FF`.
- SH at 0x80000002, wdata 0x0000ABCD → `mem_we=1`, `mem_wstrb=4'b1100`, `mem_wdata=0xABCDABCD`, and `out_valid` with `out_wen=0` after the rvalid ack.
- LW at 0x80000001 → no `mem_req` ever asserted, `out_valid` at cycle 1, `out_misalign=1`, `out_wen=0`.
- Backpressure: gnt delayed 3 cycles and `out_ready` low for 2 cycles → `mem_req` and all request fields stable throughout, `out_*` stable, exactly one transaction issued.
- Assert `rst_n=0` during RESP, then a stray `rvalid` arrives after release → outputs at reset values immediately, state IDLE, stray `rvalid` ignored, and the next LW completes normally.
